// File: rtl/e_md_if.sv
// e_md_if: E-stage multiply/divide bus between pipeline control and the HI/LO unit
//   md_op  : E-stage operation code (0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO)
//   start  : one-cycle launch pulse for ops 1-4
//   a, b   : forwarded rs/rt operands
//   busy   : operation in flight
//   hilo_E : mfhi/mflo read value
interface e_md_if;
  logic [3:0] md_op;
  logic start;
  logic [31:0] a;
  logic [31:0] b;
  logic busy;
  logic [31:0] hilo_E;
  modport master (output md_op, start, a, b, input busy, hilo_E);
  modport slave (input md_op, start, a, b, output busy, hilo_E);
endinterface

// File: rtl/e_md.sv
// e_md: MIPS E-stage multiply/divide unit owning HI/LO with fixed-latency mult/div
//   clk, reset : clock and synchronous active-high reset
//   bus        : e_md_if.slave (md_op, start, a, b in; busy, hilo_E out)
module e_md #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  e_md_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MTHI = 4'd5, OP_MTLO = 4'd6, OP_MFHI = 4'd7, OP_MFLO = 4'd8;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [31:0] hi, lo, hi_tmp, lo_tmp;
  logic [CW-1:0] cnt;
  logic dz;
  logic is_mul, is_div, go, done, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q, r, hi_d, lo_d;
  logic [63:0] prod;
  always_comb begin
    is_mul = bus.md_op == OP_MULT || bus.md_op == OP_MULTU;
    is_div = bus.md_op == OP_DIV || bus.md_op == OP_DIVU;
    go = state == IDLE && bus.start && (is_mul || is_div);
    done = state == RUN && cnt == CW'(1);
    state_n = go ? RUN : done ? IDLE : state;
  end
  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with no special case;
  // a zero divisor is replaced by 1 only to keep the datapath defined, the result is never committed.
  always_comb begin
    prod = bus.md_op == OP_MULT ? {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b}
                                : {32'b0, bus.a} * {32'b0, bus.b};
    a_neg = bus.md_op == OP_DIV && bus.a[31];
    b_neg = bus.md_op == OP_DIV && bus.b[31];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = bus.b == 32'b0 ? 32'd1 : b_neg ? -bus.b : bus.b;
    q = a_mag / b_mag;
    r = a_mag % b_mag;
    lo_d = a_neg ^ b_neg ? -q : q;
    hi_d = a_neg ? -r : r;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else begin
      if (go) begin
        hi_tmp <= is_mul ? prod[63:32] : hi_d;
        lo_tmp <= is_mul ? prod[31:0] : lo_d;
        cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        dz <= is_div && bus.b == 32'b0;
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
      end
      if (done && !dz) begin
        hi <= hi_tmp;
        lo <= lo_tmp;
      end else if (state == IDLE && !bus.start) begin
        if (bus.md_op == OP_MTHI) hi <= bus.a;
        if (bus.md_op == OP_MTLO) lo <= bus.a;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.hilo_E = bus.md_op == OP_MFHI ? hi : bus.md_op == OP_MFLO ? lo : 32'b0;
endmodule

// File: tb/tb_e_md.sv
// tb_e_md: randomized and directed check of e_md against a behavioural HI/LO model
module tb_e_md;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  e_md_if bus();
  e_md #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int m_rem = 0;
  bit p_ok = 1'b0;
  longint sa, sb, mq, mr;
  logic [63:0] r64;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_ok) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.start && bus.md_op >= 4'd1 && bus.md_op <= 4'd4) begin
      sa = longint'($signed(bus.a));
      sb = longint'($signed(bus.b));
      r64 = '0;
      if (bus.md_op == 4'd1) r64 = sa * sb;
      else if (bus.md_op == 4'd2) r64 = {32'b0, bus.a} * {32'b0, bus.b};
      else if (bus.b != 0) begin
        if (bus.md_op == 4'd3) begin
          mq = sa / sb;
          mr = sa % sb;
          r64 = {mr[31:0], mq[31:0]};
        end else r64 = {bus.a % bus.b, bus.a / bus.b};
      end
      p_hi = r64[63:32];
      p_lo = r64[31:0];
      p_ok = !(bus.md_op >= 4'd3 && bus.b == 0);
      m_rem = bus.md_op <= 4'd2 ? 5 : 10;
    end else if (!bus.start && bus.md_op == 4'd5) m_hi = bus.a;
    else if (!bus.start && bus.md_op == 4'd6) m_lo = bus.a;
  end
  always @(negedge clk) begin
    #2;
    if (checking && !reset) begin
      chk("busy", {31'b0, bus.busy}, {31'b0, m_rem > 0});
      chk("hilo_E", bus.hilo_E, bus.md_op == 4'd7 ? m_hi : bus.md_op == 4'd8 ? m_lo : 32'b0);
    end
  end
  task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.md_op = op;
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = 4'd0;
  endtask
  task automatic single(input logic [3:0] op, input logic [31:0] av);
    @(negedge clk);
    bus.md_op = op;
    bus.start = 1'b0;
    bus.a = av;
    @(negedge clk);
    bus.md_op = 4'd0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (bus.busy && n < 40);
    chk("idle_timeout", {31'b0, bus.busy}, 32'd0);
  endtask
  task automatic read(input string name, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    bus.md_op = 4'd7;
    #2 chk({name, "_hi"}, bus.hilo_E, eh);
    @(negedge clk);
    bus.md_op = 4'd8;
    #2 chk({name, "_lo"}, bus.hilo_E, el);
    @(negedge clk);
    bus.md_op = 4'd0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    bus.md_op = 4'd0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    read("reset", 32'h0, 32'h0);
    do_op(4'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle();
    read("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    read("multu", 32'h1, 32'hFFFF_FFFE);
    do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    read("mult_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    read("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(4'd4, 32'd7, 32'd2);
    wait_idle();
    read("divu", 32'd1, 32'd3);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    read("div_ovf", 32'h0, 32'h8000_0000);
    single(4'd5, 32'h11);
    single(4'd6, 32'h22);
    do_op(4'd4, 32'd7, 32'd0);
    wait_idle();
    read("div0", 32'h11, 32'h22);
    single(4'd5, 32'hDEAD_BEEF);
    read("mthi", 32'hDEAD_BEEF, 32'h22);
    do_op(4'd1, 32'd2, 32'd3);
    @(negedge clk);
    bus.md_op = 4'd6;
    bus.a = 32'h55;
    @(negedge clk);
    bus.md_op = 4'd0;
    wait_idle();
    read("mtlo_busy", 32'h0, 32'd6);
    do_op(4'd1, 32'd4, 32'd5);
    @(negedge clk);
    bus.md_op = 4'd4;
    bus.start = 1'b1;
    bus.a = 32'd100;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    wait_idle();
    read("start_busy", 32'h0, 32'd20);
    do_op(4'd1, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.md_op = 4'd7;
    #2;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hilo_E, 32'd0);
    @(negedge clk);
    bus.md_op = 4'd8;
    #2 chk("rst_lo", bus.hilo_E, 32'd0);
    do_op(4'd1, 32'd6, 32'd7);
    wait_idle();
    read("mult_42", 32'h0, 32'd42);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = $urandom_range(0, 199) == 0;
      bus.md_op = $urandom_range(0, 9) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      bus.start = $urandom_range(0, 3) == 0;
      bus.a = pick();
      bus.b = pick();
    end
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.md_op = 4'd0;
    repeat (12) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/e_md.md
# e_md

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It owns the architectural HI and LO registers. It runs mult/multu/div/divu with fixed multi-cycle latency and executes mthi/mtlo. It supplies the mfhi/mflo read value that travels down the pipeline as the HI/LO result, which the writeback stage selects as register-file write data. It exports `busy` so the hazard unit can stall subsequent multiply/divide-class instructions in D.

## Interface
- `MULT_CYCLES`, 5, number of busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, number of busy cycles for div/divu (≥1)

- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `md_op` in 4: E-stage operation; 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9–15 treated as NONE
- `start` in 1: one-cycle pulse in the cycle a mult/multu/div/divu instruction is in E; ignored unless `md_op` ∈ 1–4
- `a` in 32: rs operand, forwarded value
- `b` in 32: rt operand, forwarded value
- `busy` out 1: high while an operation is in flight
- `hilo_E` out 32: HI when `md_op`=MFHI, LO when MFLO, else 0

## Operation
- State: `hi`, `lo` (32 each), `hi_tmp`, `lo_tmp` (32 each), `cnt` (width clog2(max(MULT_CYCLES,DIV_CYCLES)+1)), `busy` flag.
- Two states, IDLE (`busy`=0) and RUN (`busy`=1).
- IDLE + `start` + op 1–4: compute the result from `a`/`b` into `hi_tmp`/`lo_tmp`, load `cnt` with MULT_CYCLES or DIV_CYCLES, and go to RUN.
- RUN: `cnt` decrements each cycle. On the edge where `cnt` is 1, copy tmp to `hi`/`lo`, clear `busy` and return to IDLE.
- MULT: {hi,lo} = signed(a) × signed(b), 64-bit.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
- DIV with a = 0x80000000 and b = 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b = 0, DIV or DIVU): the unit still goes busy for DIV_CYCLES, but `hi`/`lo` are NOT updated at completion. A per-operation flag records this.
- MTHI/MTLO in IDLE: `hi` (or `lo`) ← `a` at the end of the cycle.
- MTHI/MTLO while `busy`=1 or `start`=1: ignored.
- `start` while `busy`=1: ignored; the in-flight operation is unaffected. The hazard unit prevents this; benches flag it as an assertion.
- MFHI/MFLO: combinational read of the current `hi`/`lo`. During RUN this returns the pre-operation values. The hazard unit prevents such a read from reaching E.
- `reset` has priority over all inputs.

## Timing
- Reset values: `hi`=0, `lo`=0, tmp=0, `cnt`=0, `busy`=0, `hilo_E`=0 (md_op is NONE after reset).
- Reset mid-operation: the result is discarded, and `busy` is 0 and `hi`/`lo` are 0 in the cycle after the reset edge.
- Let cycle T be the `start` cycle and N the latency:
  - `busy`=0 in T and `busy`=1 in T+1…T+N.
  - `hi`/`lo` take the new value at the edge ending T+N.
  - MFHI in T+N+1 returns the new value.
- The hazard unit stalls on (`start` | `busy`) together with a D-stage md-class op. This block does not stall itself.
- Back-to-back operation: `start` is accepted in T+N+1, the first cycle `busy`=0.
- MTHI in cycle X: MFHI in X+1 sees `a`. An MFHI in the same cycle X sees the old value.

## Test plan
- MULT: a=0xFFFFFFFD (−3), b=5, `start` in T → `busy`=1 exactly in T+1…T+5; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MFHI/MFLO in T+6 return these.
- MULTU: a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Repeat as MULT → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV: a=0xFFFFFFF9 (−7), b=2 → 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU: a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: with hi=0x11, lo=0x22, DIVU a=7, b=0 → `busy` for 10 cycles, then hi/lo remain 0x11/0x22.
- MTHI a=0xDEADBEEF in IDLE → MFHI next cycle = 0xDEADBEEF.
- MTLO issued while busy → lo unchanged after completion.
- Second `start` during busy → ignored; the first result is committed.
- Reset asserted in the 3rd busy cycle of MULT → next cycle `busy`=0, hi=lo=0, `hilo_E`=0. Afterwards a fresh MULT 6×7 gives lo=42, hi=0.
